// File: rtl/f2_vector_sequencer.sv
// Stimulus/capture sequencer for the 4-input f2 block: walks all 16 vectors,
// samples f2 after a settle time, and grades the captured truth table.
module f2_vector_sequencer #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = 16'hE8C0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        f2,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] table_q,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err_idx,
  output logic        first_err_valid
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [15:0] EXPECTED_TABLE = EXPECTED;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_r;
  logic [3:0]       idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       vec_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [15:0]      table_r;
  logic [4:0]       err_count_r;
  logic [3:0]       first_err_idx_r;
  logic             first_err_valid_r;
  logic             mismatch_s;

  assign mismatch_s = (f2 != EXPECTED_TABLE[idx_r]);

  assign {a, b, c, d}    = vec_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign pass            = pass_r;
  assign table_q         = table_r;
  assign err_count       = err_count_r;
  assign first_err_idx   = first_err_idx_r;
  assign first_err_valid = first_err_valid_r;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= IDLE;
      idx_r             <= 4'd0;
      cnt_r             <= '0;
      vec_r             <= 4'd0;
      busy_r            <= 1'b0;
      done_r            <= 1'b0;
      pass_r            <= 1'b0;
      table_r           <= 16'd0;
      err_count_r       <= 5'd0;
      first_err_idx_r   <= 4'd0;
      first_err_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r           <= DRIVE;
            idx_r             <= 4'd0;
            cnt_r             <= '0;
            vec_r             <= 4'd0;
            busy_r            <= 1'b1;
            done_r            <= 1'b0;
            pass_r            <= 1'b0;
            table_r           <= 16'd0;
            err_count_r       <= 5'd0;
            first_err_idx_r   <= 4'd0;
            first_err_valid_r <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        DRIVE: begin
          if (cnt_r == CNT_LAST) begin
            state_r <= SAMPLE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        SAMPLE: begin
          table_r[idx_r] <= f2;
          if (mismatch_s) begin
            err_count_r <= err_count_r + 5'd1;
            if (!first_err_valid_r) begin
              first_err_idx_r   <= idx_r;
              first_err_valid_r <= 1'b1;
            end else begin
              first_err_valid_r <= 1'b1;
            end
          end else begin
            err_count_r <= err_count_r;
          end
          // Vector 15 is terminal; the final mismatch must be folded into pass.
          if (idx_r == 4'd15) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (err_count_r == 5'd0) && !mismatch_s;
          end else begin
            state_r <= DRIVE;
            idx_r   <= idx_r + 4'd1;
            vec_r   <= idx_r + 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
